pool_window_gen: RTL and testbench
==================================

# pool_window_gen

Upstream stage of the pooling engine. Accepts the raw feature-map pixel stream over AXI-Stream, one 32-bit word per pixel holding 4 int8 channels, in row-major order. It buffers one even row, pairs it with the following odd row, and emits one complete non-overlapping 2x2 window per output handshake for the max-pool datapath. Frame geometry is supplied by the APB register block; start/done handshakes feed the pool clock counter.

## Interface
- `C_S00_AXIS_TDATA_WIDTH`, 32, pixel word width (4 int8 channels)
- `MAX_WIDTH`, 64, maximum pixels per row; sets line-buffer depth
- `CNT_W`, 8, width of geometry and counter fields
- `clk`  in  1  single clock; all logic rising-edge
- `rstn`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a frame; ignored while `busy`=1
- `width`  in  CNT_W  pixels per row; sampled on accepted `start`; bit 0 forced to 0
- `height`  in  CNT_W  rows per frame; sampled on accepted `start`; bit 0 forced to 0
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse, frame complete
- `err`  out  1  sticky TLAST-mismatch flag; cleared on accepted `start`
- `S_AXIS_TREADY`  out  1  input ready
- `S_AXIS_TDATA`  in  C_S00_AXIS_TDATA_WIDTH  pixel
- `S_AXIS_TLAST`  in  1  marks last pixel of frame
- `S_AXIS_TVALID`  in  1  input valid
- `win_valid`  out  1  window valid
- `win_ready`  in  1  consumer ready
- `win_data`  out  4*C_S00_AXIS_TDATA_WIDTH  window {br, bl, tr, tl}; tl at [31:0]
- `win_last`  out  1  final window of frame

## Operation
- States: IDLE, FILL, PAIR, DRAIN, DONE.
- IDLE → FILL on `start`, latching the geometry.
  - If the latched width or height is 0, go IDLE → DONE instead.
- FILL (even row):
  - Each accepted pixel is written to `line_buf[col]`.
  - At `col`=W-1: reset col to 0, go to PAIR.
- PAIR (odd row):
  - Even col: the accepted pixel is latched as `bl`, and `line_buf[col]` is latched as `tl`.
  - Odd col: load the output register with {pixel, bl, line_buf[col], tl} and set `win_valid`.
  - At `col`=W-1:
    - If the row was the last row: go to DRAIN.
    - Otherwise: go to FILL and increment the row count by 2.
- DRAIN: wait for the handshake on the final window, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `win_last`=1 with the window formed at the last odd column of the last odd row.
- Output register is a single entry. `win_data` and `win_last` are held stable while `win_valid`=1 and `win_ready`=0.
- Line buffer: register array of depth MAX_WIDTH with combinational read.
  - Writes in FILL and reads in PAIR never alias within a row.
- Counters `col` and `row` are CNT_W bits and saturate-free. A width above MAX_WIDTH is a programming error; behaviour is unspecified beyond no lock-up.
- `start` while `busy`: ignored; geometry is unchanged.
- Reset mid-frame: all state, counters, and outputs clear immediately. Partial line-buffer contents are don't-care.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `err`=0, `win_valid`=0, `win_last`=0, `S_AXIS_TREADY`=0, `win_data`=0.
  - State IDLE; `col`=0, `row`=0.
- `busy` rises the cycle after an accepted `start` and falls in the cycle `done` is asserted.
- `S_AXIS_TREADY`:
  - FILL: 1.
  - PAIR: `~win_valid | win_ready`.
  - IDLE, DRAIN, DONE: 0.
- Window latency: `win_valid`=1 the cycle after the odd-column pixel handshake.
- Throughput: 1 pixel/cycle under no backpressure. A simultaneous window handshake and new window load in the same cycle is legal.
- `done` rises exactly 1 cycle after the final `win_valid & win_ready` cycle.
- Zero-geometry frame: `done` is asserted 2 cycles after `start`, with no pixels consumed.

## Configuration
- Macro `POOL_WINGEN_TLAST_CHECK_EN`.
- Defined:
  - On every accepted pixel, compare `S_AXIS_TLAST` against (last row & last col).
  - Any mismatch sets `err`, which stays set until the next accepted `start`.
  - Frame sequencing is unaffected.
- Undefined: `err` is tied to 0 and `S_AXIS_TLAST` is ignored.

## Test plan
- W=4, H=2, pixels 0x01..0x08 with TLAST on 0x08, `win_ready`=1:
  - windows {0x06,0x05,0x02,0x01} then {0x08,0x07,0x04,0x03};
  - `win_last` only on the second window;
  - `done` 1 cycle after the second handshake.
- Same frame, `win_ready` held 0 for 5 cycles after the first `win_valid`:
  - `win_data` stable throughout;
  - `S_AXIS_TREADY`=0 in PAIR while the window is stalled;
  - no pixel is lost.
- W=2, H=4, pixels 1..8: windows {4,3,2,1} and {8,7,6,5}; `busy` high throughout; `done` pulses once.
- With `POOL_WINGEN_TLAST_CHECK_EN`, W=4, H=2, TLAST on pixel 7: `err`=1 after pixel 7, still 1 after `done`, cleared by the next `start`.
- Deassert `rstn` after 3 pixels of a frame: all outputs 0 asynchronously. A following W=2, H=2 frame 9,10,11,12 yields {12,11,10,9}.
- `start` with W=0: `done` after 2 cycles, `S_AXIS_TREADY` stays 0, and no `win_valid`.

Source files
------------

// File: rtl/pool_window_gen.sv
// pool_window_gen
// ----------------------------------------------------------------------------
// Purpose: takes a row-major AXI-Stream pixel stream (one 32-bit word = 4 int8
// channels per pixel). It stores each even row in a line buffer and pairs it
// with the following odd row. For each odd-row pixel pair it emits one
// non-overlapping 2x2 window for the max-pool datapath.
//
// Optional feature macro: POOL_WINGEN_TLAST_CHECK_EN
//   defined   : each accepted pixel's TLAST is compared with
//               (last row & last col). A mismatch sets the sticky err flag.
//   undefined : err is tied to 0 and S_AXIS_TLAST is ignored.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   start            one-cycle frame start pulse (ignored unless idle)
//   width, height    frame geometry; sampled on an accepted start, bit 0 forced 0
//   busy, done       frame in progress / one-cycle completion pulse
//   err              sticky TLAST mismatch flag, cleared by an accepted start
//   S_AXIS_*         pixel input stream (TDATA, TLAST, TVALID, TREADY)
//   win_valid/ready  window output handshake
//   win_data         {br, bl, tr, tl}, tl in the low word
//   win_last         marks the final window of the frame
//   state_dbg        current FSM state (IDLE=0 FILL=1 PAIR=2 DRAIN=3 DONE=4)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A source never drops valid or changes data before that edge.
// Ready may depend combinationally on the consumer's ready.
// ----------------------------------------------------------------------------
module pool_window_gen #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_WIDTH              = 64,
  parameter int CNT_W                  = 8
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic [CNT_W-1:0]                    width,
  input  logic [CNT_W-1:0]                    height,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic                                S_AXIS_TREADY,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_TVALID,
  output logic                                win_valid,
  input  logic                                win_ready,
  output logic [4*C_S00_AXIS_TDATA_WIDTH-1:0] win_data,
  output logic                                win_last,
  output logic [2:0]                          state_dbg
);

  localparam int DW = C_S00_AXIS_TDATA_WIDTH;
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [CNT_W-1:0] ONE = 1;
  localparam logic [CNT_W-1:0] TWO = 2;

  typedef enum logic [2:0] {IDLE, FILL, PAIR, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] w_q, h_q, col, row;
  logic [DW-1:0]    line_buf [MAX_WIDTH];
  logic [DW-1:0]    tl, bl, tr_rd;
  logic             pix_acc, last_col, last_row;

  assign state_dbg = state;

  // In PAIR a pixel may only be taken when the single-entry output register
  // is free or is being emptied in the same cycle.
  assign S_AXIS_TREADY = (state == FILL) |
                         ((state == PAIR) & (~win_valid | win_ready));
  assign pix_acc  = S_AXIS_TVALID & S_AXIS_TREADY;
  assign last_col = (col == w_q - ONE);
  assign last_row = (row == h_q - TWO);
  // Widths above MAX_WIDTH wrap the index; this is harmless and cannot lock up.
  assign tr_rd    = line_buf[col[AW-1:0]];

  // Line buffer: no reset, because stale contents are always overwritten
  // before they are read.
  always_ff @(posedge clk) begin
    if ((state == FILL) && pix_acc) line_buf[col[AW-1:0]] <= S_AXIS_TDATA;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_q       <= '0;
      h_q       <= '0;
      col       <= '0;
      row       <= '0;
      tl        <= '0;
      bl        <= '0;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (win_valid && win_ready) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            w_q  <= {width[CNT_W-1:1], 1'b0};
            h_q  <= {height[CNT_W-1:1], 1'b0};
            col  <= '0;
            row  <= '0;
            busy <= 1'b1;
            if ((width[CNT_W-1:1] == '0) || (height[CNT_W-1:1] == '0)) state <= DONE;
            else state <= FILL;
          end
        end
        FILL: begin
          if (pix_acc) begin
            if (last_col) begin
              col   <= '0;
              state <= PAIR;
            end else begin
              col <= col + ONE;
            end
          end
        end
        PAIR: begin
          if (pix_acc) begin
            if (!col[0]) begin
              bl <= S_AXIS_TDATA;
              tl <= tr_rd;
            end else begin
              // This load overrides the handshake clear above, so a window
              // can be consumed and the next one loaded in the same cycle.
              win_data  <= {S_AXIS_TDATA, bl, tr_rd, tl};
              win_valid <= 1'b1;
              win_last  <= last_col & last_row;
            end
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                state <= DRAIN;
              end else begin
                state <= FILL;
                row   <= row + TWO;
              end
            end else begin
              col <= col + ONE;
            end
          end
        end
        DRAIN: begin
          if (win_ready || !win_valid) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          // Entered from DRAIN with done already set. A zero-geometry frame
          // enters with done clear and raises it here one cycle later.
          if (done) begin
            state <= IDLE;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef POOL_WINGEN_TLAST_CHECK_EN
  logic tlast_exp;
  assign tlast_exp = (state == PAIR) & last_row & last_col;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if ((state == IDLE) && start) begin
      err <= 1'b0;
    end else if (pix_acc && (S_AXIS_TLAST != tlast_exp)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = S_AXIS_TLAST;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_pool_window_gen.sv
// tb_pool_window_gen
// ----------------------------------------------------------------------------
// Self-checking bench for pool_window_gen. Each frame is described as a
// pixel array. The expected 2x2 windows are built from that array by
// row/column arithmetic. Ready, window-valid, busy, done and err are
// predicted from how many pixels and windows have been exchanged so far.
// ----------------------------------------------------------------------------
module tb_pool_window_gen;

  localparam int DW = 32;
  localparam int MW = 64;
  localparam int CW = 8;
`ifdef POOL_WINGEN_TLAST_CHECK_EN
  localparam bit TLAST_CHK = 1'b1;
`else
  localparam bit TLAST_CHK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic [CW-1:0]   width = '0, height = '0;
  logic            busy, done, err, tready;
  logic [DW-1:0]   tdata = '0;
  logic            tlast = 1'b0, tvalid = 1'b0;
  logic            win_valid, win_last;
  logic            win_ready = 1'b0;
  logic [4*DW-1:0] win_data;
  logic [2:0]      state_dbg;

  pool_window_gen #(
    .C_S00_AXIS_TDATA_WIDTH(DW),
    .MAX_WIDTH(MW),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .width(width), .height(height),
    .busy(busy), .done(done), .err(err),
    .S_AXIS_TREADY(tready), .S_AXIS_TDATA(tdata), .S_AXIS_TLAST(tlast),
    .S_AXIS_TVALID(tvalid),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_last(win_last), .state_dbg(state_dbg)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [4*DW:0] exp_q[$];   // {last, br, bl, tr, tl}
  logic exp_err = 1'b0;

  // One frame: start, stream pixels, consume windows, check every cycle.
  // base >= 0 gives pixels base, base+1, ...; otherwise random pixels.
  // tlast_idx < 0 puts TLAST on the true last pixel.
  task automatic run_frame(input int w, input int h, input int base,
                           input int vprob, input int rprob, input int stall,
                           input int tlast_idx, input bit busy_start,
                           input string name);
    logic [DW-1:0] pix[$];
    int we, he, n, idx, formed, consumed, done_cyc, stall_left, budget, cyc;
    bit fin, stall_seen, exp_wv, exp_rdy, exp_busy, exp_done;
    we = w & ~1;
    he = h & ~1;
    n  = we * he;
    if (tlast_idx < 0) tlast_idx = n - 1;
    for (int i = 0; i < n; i++) pix.push_back(base >= 0 ? DW'(base + i) : DW'($urandom));
    exp_q.delete();
    for (int r = 0; r < he; r += 2)
      for (int c = 0; c < we; c += 2)
        exp_q.push_back({(r == he - 2) && (c == we - 2),
                         pix[(r+1)*we + c + 1], pix[(r+1)*we + c],
                         pix[r*we + c + 1], pix[r*we + c]});

    // start cycle (cyc 0)
    @(negedge clk);
    start = 1'b1; width = CW'(w); height = CW'(h); tvalid = 1'b0; win_ready = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || tready !== 1'b0 || win_valid !== 1'b0 || err !== exp_err) begin
      $display("FAIL %s start: busy=%0b tready=%0b wv=%0b err=%0b, want 0 0 0 %0b",
               name, busy, tready, win_valid, err, exp_err);
      n_err++;
    end
    exp_err = 1'b0;
    @(negedge clk);
    start = 1'b0;

    idx = 0; formed = 0; consumed = 0; stall_left = 0; stall_seen = 0; fin = 0;
    done_cyc = (n == 0) ? 2 : -1;
    budget = 40 + 20 * n;
    for (cyc = 1; cyc < budget && !fin; cyc++) begin
      exp_wv = (formed > consumed);
      if (exp_wv && stall > 0 && !stall_seen) begin
        stall_seen = 1;
        stall_left = stall;
      end
      tvalid = (idx < n) && ($urandom_range(99) < vprob);
      tdata  = (idx < n) ? pix[idx] : DW'($urandom);
      tlast  = tvalid && (idx == tlast_idx);
      if (stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
      end else begin
        win_ready = ($urandom_range(99) < rprob);
      end
      start = busy_start && (cyc == 3);
      if (start) begin width = 2; height = 2; end
      #1;

      if (idx < n) exp_rdy = (((idx / we) % 2) == 0) ? 1'b1 : (~exp_wv | win_ready);
      else exp_rdy = 1'b0;
      exp_busy = (done_cyc < 0) || (cyc < done_cyc);
      exp_done = (cyc == done_cyc);

      n_vec++;
      if (tready !== exp_rdy) begin
        $display("FAIL %s tready cyc %0d: got %0b want %0b", name, cyc, tready, exp_rdy);
        n_err++;
      end
      n_vec++;
      if (win_valid !== exp_wv) begin
        $display("FAIL %s win_valid cyc %0d: got %0b want %0b", name, cyc, win_valid, exp_wv);
        n_err++;
      end
      n_vec++;
      if (busy !== exp_busy || done !== exp_done) begin
        $display("FAIL %s busy/done cyc %0d: got %0b/%0b want %0b/%0b",
                 name, cyc, busy, done, exp_busy, exp_done);
        n_err++;
      end
      n_vec++;
      if (err !== exp_err) begin
        $display("FAIL %s err cyc %0d: got %0b want %0b", name, cyc, err, exp_err);
        n_err++;
      end
      if (exp_wv) begin
        n_vec++;
        if ({win_last, win_data} !== exp_q[0]) begin
          $display("FAIL %s window cyc %0d: got last=%0b data=%h want last=%0b data=%h",
                   name, cyc, win_last, win_data, exp_q[0][4*DW], exp_q[0][4*DW-1:0]);
          n_err++;
        end
      end

      // advance the model by what happens at the coming clock edge
      if (tvalid && exp_rdy) begin
        if (TLAST_CHK && (tlast != (idx == n - 1))) exp_err = 1'b1;
        if (((idx / we) % 2 == 1) && ((idx % we) % 2 == 1)) formed++;
        idx++;
      end
      if (exp_wv && win_ready) begin
        void'(exp_q.pop_front());
        consumed++;
        if (exp_q.size() == 0) done_cyc = cyc + 1;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 1) fin = 1;
      if (!fin) @(negedge clk);
    end
    tvalid = 1'b0; tlast = 1'b0; win_ready = 1'b0; start = 1'b0;

    n_vec++;
    if (!fin || exp_q.size() != 0 || idx != n) begin
      $display("FAIL %s completion: finished=%0b windows_left=%0d pixels=%0d, want 1 0 %0d",
               name, fin, exp_q.size(), idx, n);
      n_err++;
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (busy !== 0 || done !== 0 || err !== 0 || win_valid !== 0 || win_last !== 0 ||
        tready !== 0 || win_data !== '0) begin
      $display("FAIL reset: busy=%0b done=%0b err=%0b wv=%0b wl=%0b tready=%0b data=%h, want all 0",
               busy, done, err, win_valid, win_last, tready, win_data);
      n_err++;
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    run_frame(4, 2, 1, 100, 100, 0, -1, 0, "basic_w4h2");
  endtask

  task automatic test_backpressure();
    run_frame(4, 2, 1, 100, 100, 5, -1, 0, "stall5_w4h2");
    run_frame(8, 4, -1, 100, 100, 7, -1, 0, "stall7_w8h4");
  endtask

  task automatic test_w2h4();
    run_frame(2, 4, 1, 100, 100, 0, -1, 0, "w2h4");
  endtask

  task automatic test_tlast();
    run_frame(4, 2, 1, 100, 100, 0, 6, 0, "tlast_early");
    run_frame(4, 4, -1, 80, 80, 0, -1, 0, "tlast_clear");
  endtask

  task automatic test_zero_geometry();
    run_frame(0, 4, 1, 100, 100, 0, -1, 0, "zero_w0");
    run_frame(1, 6, 1, 100, 100, 0, -1, 0, "zero_w1");
    run_frame(6, 0, 1, 100, 100, 0, -1, 0, "zero_h0");
  endtask

  task automatic test_start_while_busy();
    run_frame(8, 4, -1, 100, 70, 0, -1, 1, "start_busy");
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    start = 1'b1; width = 4; height = 2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1; tdata = DW'(100 + i); tlast = (i == 0);
      @(negedge clk);
    end
    tvalid = 1'b0; tlast = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b1 || err !== TLAST_CHK) begin
      $display("FAIL pre_reset: busy=%0b err=%0b want 1 %0b", busy, err, TLAST_CHK);
      n_err++;
    end
    #1 rstn = 1'b0;
    #1;
    n_vec++;
    if (busy !== 0 || done !== 0 || err !== 0 || win_valid !== 0 || win_last !== 0 ||
        tready !== 0 || win_data !== '0) begin
      $display("FAIL async_reset: busy=%0b done=%0b err=%0b wv=%0b wl=%0b tready=%0b data=%h, want all 0",
               busy, done, err, win_valid, win_last, tready, win_data);
      n_err++;
    end
    exp_err = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_frame(2, 2, 9, 100, 100, 0, -1, 0, "after_reset_w2h2");
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++)
      run_frame(2 * $urandom_range(1, 16), 2 * $urandom_range(1, 6), -1,
                $urandom_range(40, 100), $urandom_range(30, 100), 0, -1, 0, "random");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++)
      run_frame(2 * $urandom_range(1, 4), 2 * $urandom_range(1, 3), -1,
                100, 100, 0, -1, 0, "back_to_back");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_w2h4();
    test_tlast();
    test_zero_geometry();
    test_start_while_busy();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
